// File: rtl/cmndf_pitch_seq.sv
// cmndf_pitch_seq: YIN pitch-path sequencer around an external fixed-point divider.
// Walks tau = 1..TAU_MAX-1 over the difference function d(tau) in the diff BRAM.
// For each tau it keeps a saturating running sum of d and forms
// d'(tau) = d(tau)*tau / sum, either directly or through one divider request.
// It then applies the absolute-threshold / local-minimum search and reports
// the detected period.
//
// Ports:
//   clk_in, rst_in           clock, synchronous active-high reset
//   start_in                 begin a search (sampled in IDLE only)
//   busy_out                 search in progress, through the result cycle
//   addr_out / rdata_in      diff BRAM read port (RAM_LATENCY read latency)
//   dividend_out, divisor_out, div_valid_out   divider request
//   div_busy_in              divider cannot accept a request
//   quotient_in, div_valid_in, div_err_in      divider result
//   tau_out, min_val_out, found_out, valid_out result, valid_out pulses once
module cmndf_pitch_seq #(
    parameter int unsigned WIDTH          = 42,
    parameter int unsigned FRACTION_WIDTH = 10,
    parameter int unsigned INT_WIDTH      = WIDTH - FRACTION_WIDTH,
    parameter int unsigned TAU_MAX        = 1024,
    parameter int unsigned ADDR_WIDTH     = $clog2(TAU_MAX),
    parameter int unsigned RAM_LATENCY    = 2,
    parameter int unsigned THRESHOLD      = 102
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      start_in,
    output logic                      busy_out,
    output logic [ADDR_WIDTH-1:0]     addr_out,
    input  logic [INT_WIDTH-1:0]      rdata_in,
    output logic [INT_WIDTH-1:0]      dividend_out,
    output logic [INT_WIDTH-1:0]      divisor_out,
    output logic                      div_valid_out,
    input  logic                      div_busy_in,
    input  logic [FRACTION_WIDTH:0]   quotient_in,
    input  logic                      div_valid_in,
    input  logic                      div_err_in,
    output logic [ADDR_WIDTH-1:0]     tau_out,
    output logic [FRACTION_WIDTH:0]   min_val_out,
    output logic                      found_out,
    output logic                      valid_out
);

    localparam int unsigned Q_WIDTH = FRACTION_WIDTH + 1;
    localparam int unsigned PROD_W  = INT_WIDTH + ADDR_WIDTH;
    localparam int unsigned CNT_W   = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;

    localparam logic [Q_WIDTH-1:0]    Q_ONE    = Q_WIDTH'(1) << FRACTION_WIDTH;
    localparam logic [Q_WIDTH-1:0]    Q_SAT    = '1;
    localparam logic [Q_WIDTH-1:0]    Q_THR    = Q_WIDTH'(THRESHOLD);
    localparam logic [ADDR_WIDTH-1:0] TAU_LAST = ADDR_WIDTH'(TAU_MAX - 1);
    localparam logic [ADDR_WIDTH-1:0] TAU_ONE  = ADDR_WIDTH'(1);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(RAM_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_ACCUM, S_CHECK, S_ISSUE, S_WAIT, S_EVAL, S_DONE
    } state_e;

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [ADDR_WIDTH-1:0]  tau_q;
    logic [INT_WIDTH-1:0]   sum_q;
    logic [INT_WIDTH-1:0]   prod_q;
    logic [Q_WIDTH-1:0]     q_q;
    logic [ADDR_WIDTH-1:0]  best_tau_q;
    logic [Q_WIDTH-1:0]     best_q_q;
    logic                   found_q;

    logic                   busy_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [INT_WIDTH-1:0]   dividend_q;
    logic [INT_WIDTH-1:0]   divisor_q;
    logic                   div_valid_q;
    logic [ADDR_WIDTH-1:0]  tau_out_q;
    logic [Q_WIDTH-1:0]     min_val_q;
    logic                   found_out_q;
    logic                   valid_q;

    // Saturating running sum and saturating d*tau product
    logic [INT_WIDTH:0]     sum_ext_d;
    logic [INT_WIDTH-1:0]   sum_d;
    logic [PROD_W-1:0]      prod_full_d;
    logic [INT_WIDTH-1:0]   prod_d;
    logic                   prod_big_d;

    assign sum_ext_d   = {1'b0, sum_q} + {1'b0, rdata_in};
    assign sum_d       = sum_ext_d[INT_WIDTH] ? '1 : sum_ext_d[INT_WIDTH-1:0];
    assign prod_full_d = PROD_W'(rdata_in) * PROD_W'(tau_q);
    assign prod_d      = (|prod_full_d[PROD_W-1:INT_WIDTH]) ? '1 : prod_full_d[INT_WIDTH-1:0];
    // Ratio would be >= 2.0, i.e. beyond the Q1 quotient range
    assign prod_big_d  = {1'b0, prod_q} >= {sum_q, 1'b0};

    // Search decision for the current q: take = record (tau, q), stop = end scan
    logic take_d;
    logic found_d;
    logic stop_d;

    always_comb begin
        take_d  = 1'b0;
        found_d = found_q;
        stop_d  = (tau_q == TAU_LAST);
        if (!found_q) begin
            if (q_q < Q_THR) begin
                take_d  = 1'b1;
                found_d = 1'b1;
            end else if (tau_q == TAU_ONE || q_q < best_q_q) begin
                take_d = 1'b1;
            end
        end else if (q_q < best_q_q) begin
            take_d = 1'b1;
        end else begin
            stop_d = 1'b1;
        end
    end

    // Sequencer state machine with registered outputs
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            tau_q       <= '0;
            sum_q       <= '0;
            prod_q      <= '0;
            q_q         <= '0;
            best_tau_q  <= '0;
            best_q_q    <= '0;
            found_q     <= 1'b0;
            busy_q      <= 1'b0;
            addr_q      <= '0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            div_valid_q <= 1'b0;
            tau_out_q   <= '0;
            min_val_q   <= '0;
            found_out_q <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            div_valid_q <= 1'b0;
            valid_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_in) begin
                        busy_q  <= 1'b1;
                        tau_q   <= TAU_ONE;
                        addr_q  <= TAU_ONE;
                        sum_q   <= '0;
                        found_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    // rdata_in carries d(tau) in the cycle after this wait
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_ACCUM;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_ACCUM: begin
                    sum_q   <= sum_d;
                    prod_q  <= prod_d;
                    state_q <= S_CHECK;
                end
                S_CHECK: begin
                    if (sum_q == '0) begin
                        q_q     <= Q_ONE;
                        state_q <= S_EVAL;
                    end else if (prod_big_d) begin
                        q_q     <= Q_SAT;
                        state_q <= S_EVAL;
                    end else begin
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!div_busy_in) begin
                        div_valid_q <= 1'b1;
                        dividend_q  <= prod_q;
                        divisor_q   <= sum_q;
                        state_q     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (div_valid_in) begin
                        q_q     <= div_err_in ? Q_SAT : quotient_in;
                        state_q <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (take_d) begin
                        best_tau_q <= tau_q;
                        best_q_q   <= q_q;
                    end
                    found_q <= found_d;
                    if (stop_d) begin
                        valid_q     <= 1'b1;
                        tau_out_q   <= take_d ? tau_q : best_tau_q;
                        min_val_q   <= take_d ? q_q : best_q_q;
                        found_out_q <= found_d;
                        state_q     <= S_DONE;
                    end else begin
                        tau_q   <= tau_q + TAU_ONE;
                        addr_q  <= tau_q + TAU_ONE;
                        cnt_q   <= '0;
                        state_q <= S_FETCH;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_out      = busy_q;
    assign addr_out      = addr_q;
    assign dividend_out  = dividend_q;
    assign divisor_out   = divisor_q;
    assign div_valid_out = div_valid_q;
    assign tau_out       = tau_out_q;
    assign min_val_out   = min_val_q;
    assign found_out     = found_out_q;
    assign valid_out     = valid_q;

endmodule

// File: tb/tb_cmndf_pitch_seq.sv
// Directed bench for cmndf_pitch_seq with TAU_MAX=8, a two-stage BRAM model
// and a behavioural divider (fixed latency, Q1.10 quotient).
module tb_cmndf_pitch_seq;

    localparam int DIV_LAT = 4;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        start_in;
    logic        busy_out;
    logic [2:0]  addr_out;
    logic [31:0] rdata_in;
    logic [31:0] dividend_out;
    logic [31:0] divisor_out;
    logic        div_valid_out;
    logic        div_busy_in;
    logic [10:0] quotient_in;
    logic        div_valid_in;
    logic        div_err_in;
    logic [2:0]  tau_out;
    logic [10:0] min_val_out;
    logic        found_out;
    logic        valid_out;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    cmndf_pitch_seq #(
        .WIDTH(42), .FRACTION_WIDTH(10), .TAU_MAX(8), .RAM_LATENCY(2), .THRESHOLD(102)
    ) dut (
        .clk_in(clk), .rst_in(rst_in), .start_in(start_in), .busy_out(busy_out),
        .addr_out(addr_out), .rdata_in(rdata_in),
        .dividend_out(dividend_out), .divisor_out(divisor_out),
        .div_valid_out(div_valid_out), .div_busy_in(div_busy_in),
        .quotient_in(quotient_in), .div_valid_in(div_valid_in), .div_err_in(div_err_in),
        .tau_out(tau_out), .min_val_out(min_val_out), .found_out(found_out),
        .valid_out(valid_out)
    );

    // Diff BRAM: data appears two cycles after the address
    logic [31:0] mem [0:7];
    logic [31:0] rd_p1;
    always @(posedge clk) begin
        rd_p1    <= mem[addr_out];
        rdata_in <= rd_p1;
    end

    // Behavioural divider
    logic        dv_busy = 1'b0;
    logic        dv_valid = 1'b0;
    logic        dv_err = 1'b0;
    logic [10:0] dv_q = '0;
    logic [31:0] dv_dvd, dv_dvs;
    int          dv_cnt = 0;
    int          cur_idx = 0;
    int          req_cnt = 0;
    int          prot_viol = 0;
    int          err_at_req = -1;
    logic        force_busy;
    logic        busy_prev = 1'b0;
    logic [31:0] req_dvd [0:511];
    logic [31:0] req_dvs [0:511];

    assign div_busy_in  = dv_busy | force_busy;
    assign quotient_in  = dv_q;
    assign div_valid_in = dv_valid;
    assign div_err_in   = dv_err;

    function automatic logic [10:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        longint unsigned t;
        if (b == 32'd0) return '1;
        t = ({32'd0, a} << 10) / {32'd0, b};
        if (t > 64'd2047) t = 64'd2047;
        return 11'(t);
    endfunction

    always @(posedge clk) begin
        dv_valid  <= 1'b0;
        dv_err    <= 1'b0;
        busy_prev <= div_busy_in;
        if (rst_in) begin
            dv_busy <= 1'b0;
            dv_cnt  <= 0;
        end else begin
            if (div_valid_out && busy_prev) prot_viol <= prot_viol + 1;
            if (dv_busy) begin
                if (div_valid_out) prot_viol <= prot_viol + 1;
                if (dv_cnt == 1) begin
                    dv_busy  <= 1'b0;
                    dv_valid <= 1'b1;
                    dv_q     <= (cur_idx == err_at_req) ? 11'd0 : ref_div(dv_dvd, dv_dvs);
                    dv_err   <= (cur_idx == err_at_req) || (dv_dvs == 32'd0);
                end
                dv_cnt <= dv_cnt - 1;
            end else if (div_valid_out) begin
                dv_busy          <= 1'b1;
                dv_cnt           <= DIV_LAT;
                dv_dvd           <= dividend_out;
                dv_dvs           <= divisor_out;
                req_dvd[req_cnt] <= dividend_out;
                req_dvs[req_cnt] <= divisor_out;
                cur_idx          <= req_cnt;
                req_cnt          <= req_cnt + 1;
            end
        end
    end

    task automatic set_d(input int d1, input int d2, input int d3, input int d4,
                         input int d5, input int d6, input int d7);
        mem[0] = 32'd7777; mem[1] = 32'(d1); mem[2] = 32'(d2); mem[3] = 32'(d3);
        mem[4] = 32'(d4);  mem[5] = 32'(d5); mem[6] = 32'(d6); mem[7] = 32'(d7);
    endtask

    // Starts a search and watches it plus a 150-cycle tail for extra pulses
    task automatic run_search(input int restart_at, input bit pulse_on_valid,
                              output int nvalid, output logic [2:0] t, output logic [10:0] mv,
                              output logic f, output int maxaddr, output int nreq);
        int req0;
        int seen;
        bit prev_v;
        req0 = req_cnt; nvalid = 0; maxaddr = 0; seen = -1; prev_v = 1'b0;
        t = '0; mv = '0; f = 1'b0;
        start_in = 1'b1;
        @(posedge clk); #1;
        start_in = 1'b0;
        for (int c = 1; c < 3000; c++) begin
            start_in = (c == restart_at) || (pulse_on_valid && prev_v);
            @(posedge clk); #1;
            prev_v = valid_out;
            if (int'(addr_out) > maxaddr) maxaddr = int'(addr_out);
            if (valid_out) begin
                nvalid++;
                if (seen < 0) begin
                    seen = c; t = tau_out; mv = min_val_out; f = found_out;
                end
            end
            if (seen >= 0 && c >= seen + 150) break;
        end
        start_in = 1'b0;
        nreq = req_cnt - req0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vec_cnt++; if (busy_out !== 1'b0) begin err_cnt++; $display("FAIL reset busy_out: got %b want 0", busy_out); end
        vec_cnt++; if (valid_out !== 1'b0 || div_valid_out !== 1'b0) begin err_cnt++; $display("FAIL reset strobes: got valid=%b div_valid=%b want 0/0", valid_out, div_valid_out); end
        vec_cnt++; if (addr_out !== 3'd0 || dividend_out !== 32'd0 || divisor_out !== 32'd0) begin err_cnt++; $display("FAIL reset bus: got addr=%0d dvd=%0d dvs=%0d want 0", addr_out, dividend_out, divisor_out); end
        vec_cnt++; if (tau_out !== 3'd0 || min_val_out !== 11'd0 || found_out !== 1'b0) begin err_cnt++; $display("FAIL reset result: got tau=%0d min=%0d found=%b want 0", tau_out, min_val_out, found_out); end
        rst_in = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_flat();
        int nv, ma, nr; logic [2:0] t; logic [10:0] mv; logic f;
        set_d(100, 100, 100, 100, 100, 100, 100);
        run_search(-1, 1'b0, nv, t, mv, f, ma, nr);
        vec_cnt++; if (nv !== 1) begin err_cnt++; $display("FAIL flat valid pulses: got %0d want 1", nv); end
        vec_cnt++; if (t !== 3'd1 || mv !== 11'd1024 || f !== 1'b0) begin err_cnt++; $display("FAIL flat result: got tau=%0d min=%0d found=%b want 1/1024/0", t, mv, f); end
        vec_cnt++; if (nr !== 7) begin err_cnt++; $display("FAIL flat div requests: got %0d want 7", nr); end
        vec_cnt++; if (tau_out !== 3'd1 || min_val_out !== 11'd1024 || busy_out !== 1'b0) begin err_cnt++; $display("FAIL flat hold: got tau=%0d min=%0d busy=%b want 1/1024/0", tau_out, min_val_out, busy_out); end
    endtask

    task automatic test_early_stop();
        int nv, ma, nr, r0; logic [2:0] t; logic [10:0] mv; logic f;
        set_d(100, 100, 5, 100, 100, 100, 100);
        r0 = req_cnt;
        run_search(-1, 1'b0, nv, t, mv, f, ma, nr);
        vec_cnt++; if (t !== 3'd3 || mv !== 11'd74 || f !== 1'b1) begin err_cnt++; $display("FAIL early_stop result: got tau=%0d min=%0d found=%b want 3/74/1", t, mv, f); end
        vec_cnt++; if (ma !== 4) begin err_cnt++; $display("FAIL early_stop max addr: got %0d want 4", ma); end
        vec_cnt++; if (nr !== 4) begin err_cnt++; $display("FAIL early_stop div requests: got %0d want 4", nr); end
        vec_cnt++; if (req_dvd[r0+2] !== 32'd15 || req_dvs[r0+2] !== 32'd205) begin err_cnt++; $display("FAIL early_stop tau3 request: got %0d/%0d want 15/205", req_dvd[r0+2], req_dvs[r0+2]); end
    endtask

    task automatic test_zero();
        int nv, ma, nr; logic [2:0] t; logic [10:0] mv; logic f;
        set_d(0, 0, 0, 0, 0, 0, 0);
        run_search(-1, 1'b0, nv, t, mv, f, ma, nr);
        vec_cnt++; if (t !== 3'd1 || mv !== 11'd1024 || f !== 1'b0) begin err_cnt++; $display("FAIL zero result: got tau=%0d min=%0d found=%b want 1/1024/0", t, mv, f); end
        vec_cnt++; if (nr !== 0) begin err_cnt++; $display("FAIL zero div requests: got %0d want 0", nr); end
    endtask

    task automatic test_bypass();
        int nv, ma, nr, r0; logic [2:0] t; logic [10:0] mv; logic f;
        // tau2 still needs the divider (4000 < 4002); tau3 (15000 >= 14002) bypasses
        set_d(1, 2000, 5000, 5000, 5000, 5000, 5000);
        r0 = req_cnt;
        run_search(-1, 1'b0, nv, t, mv, f, ma, nr);
        vec_cnt++; if (nr !== 6) begin err_cnt++; $display("FAIL bypass_a div requests: got %0d want 6", nr); end
        vec_cnt++; if (req_dvd[r0+1] !== 32'd4000 || req_dvs[r0+1] !== 32'd2001) begin err_cnt++; $display("FAIL bypass_a tau2 request: got %0d/%0d want 4000/2001", req_dvd[r0+1], req_dvs[r0+1]); end
        vec_cnt++; if (req_dvd[r0+2] !== 32'd20000 || req_dvs[r0+2] !== 32'd12001) begin err_cnt++; $display("FAIL bypass_a tau4 request: got %0d/%0d want 20000/12001", req_dvd[r0+2], req_dvs[r0+2]); end
        vec_cnt++; if (t !== 3'd1 || mv !== 11'd1024 || f !== 1'b0) begin err_cnt++; $display("FAIL bypass_a result: got tau=%0d min=%0d found=%b want 1/1024/0", t, mv, f); end
        // tau1 sum==0, tau2 prod==2*sum: both bypass
        set_d(0, 100, 100, 100, 100, 100, 100);
        r0 = req_cnt;
        run_search(-1, 1'b0, nv, t, mv, f, ma, nr);
        vec_cnt++; if (nr !== 5) begin err_cnt++; $display("FAIL bypass_b div requests: got %0d want 5", nr); end
        vec_cnt++; if (req_dvd[r0] !== 32'd300 || req_dvs[r0] !== 32'd200) begin err_cnt++; $display("FAIL bypass_b first request: got %0d/%0d want 300/200", req_dvd[r0], req_dvs[r0]); end
        vec_cnt++; if (t !== 3'd1 || mv !== 11'd1024 || f !== 1'b0) begin err_cnt++; $display("FAIL bypass_b result: got tau=%0d min=%0d found=%b want 1/1024/0", t, mv, f); end
    endtask

    task automatic test_div_err();
        int nv, ma, nr; logic [2:0] t; logic [10:0] mv; logic f;
        set_d(100, 100, 100, 100, 100, 100, 100);
        err_at_req = req_cnt;
        run_search(-1, 1'b0, nv, t, mv, f, ma, nr);
        err_at_req = -1;
        // tau1 forced to 2047, tau2 (1024) becomes the earliest strict minimum
        vec_cnt++; if (t !== 3'd2 || mv !== 11'd1024 || f !== 1'b0) begin err_cnt++; $display("FAIL div_err result: got tau=%0d min=%0d found=%b want 2/1024/0", t, mv, f); end
    endtask

    task automatic test_descend();
        int nv, ma, nr; logic [2:0] t; logic [10:0] mv; logic f;
        set_d(100, 100, 5, 2, 100, 100, 100);
        run_search(-1, 1'b0, nv, t, mv, f, ma, nr);
        vec_cnt++; if (t !== 3'd4 || mv !== 11'd39 || f !== 1'b1) begin err_cnt++; $display("FAIL descend result: got tau=%0d min=%0d found=%b want 4/39/1", t, mv, f); end
        vec_cnt++; if (ma !== 5) begin err_cnt++; $display("FAIL descend max addr: got %0d want 5", ma); end
    endtask

    task automatic test_last_tau();
        int nv, ma, nr; logic [2:0] t; logic [10:0] mv; logic f;
        set_d(100, 100, 100, 100, 100, 100, 1);
        run_search(-1, 1'b0, nv, t, mv, f, ma, nr);
        vec_cnt++; if (t !== 3'd7 || mv !== 11'd11 || f !== 1'b1) begin err_cnt++; $display("FAIL last_tau result: got tau=%0d min=%0d found=%b want 7/11/1", t, mv, f); end
        vec_cnt++; if (nv !== 1) begin err_cnt++; $display("FAIL last_tau valid pulses: got %0d want 1", nv); end
    endtask

    task automatic test_restart_ignored();
        int nv, ma, nr; logic [2:0] t; logic [10:0] mv; logic f;
        set_d(100, 100, 5, 100, 100, 100, 100);
        run_search(10, 1'b1, nv, t, mv, f, ma, nr);
        vec_cnt++; if (nv !== 1) begin err_cnt++; $display("FAIL restart valid pulses: got %0d want 1", nv); end
        vec_cnt++; if (t !== 3'd3 || mv !== 11'd74 || f !== 1'b1) begin err_cnt++; $display("FAIL restart result: got tau=%0d min=%0d found=%b want 3/74/1", t, mv, f); end
        vec_cnt++; if (busy_out !== 1'b0) begin err_cnt++; $display("FAIL restart busy after done: got %b want 0", busy_out); end
    endtask

    task automatic test_reset_in_wait();
        int nv, ma, nr, c, nvr; logic [2:0] t; logic [10:0] mv; logic f;
        set_d(100, 100, 5, 100, 100, 100, 100);
        start_in = 1'b1;
        @(posedge clk); #1;
        start_in = 1'b0;
        for (c = 0; c < 200; c++) begin
            if (div_valid_out) break;
            @(posedge clk); #1;
        end
        vec_cnt++; if (c >= 200) begin err_cnt++; $display("FAIL rst_wait request timeout: got none in %0d cycles want one", c); end
        rst_in = 1'b1;
        @(posedge clk); #1;
        vec_cnt++; if (busy_out !== 1'b0 || div_valid_out !== 1'b0 || valid_out !== 1'b0) begin err_cnt++; $display("FAIL rst_wait after reset: got busy=%b div_valid=%b valid=%b want 0/0/0", busy_out, div_valid_out, valid_out); end
        rst_in = 1'b0;
        nvr = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (valid_out || busy_out) nvr++;
        end
        vec_cnt++; if (nvr !== 0) begin err_cnt++; $display("FAIL rst_wait quiet: got %0d active cycles want 0", nvr); end
        run_search(-1, 1'b0, nv, t, mv, f, ma, nr);
        vec_cnt++; if (t !== 3'd3 || mv !== 11'd74 || f !== 1'b1 || nv !== 1) begin err_cnt++; $display("FAIL rst_wait rerun: got tau=%0d min=%0d found=%b pulses=%0d want 3/74/1/1", t, mv, f, nv); end
    endtask

    task automatic test_busy_hold();
        int n, base, k;
        set_d(100, 100, 100, 100, 100, 100, 100);
        for (int pass = 0; pass < 2; pass++) begin
            force_busy = (pass == 1);
            start_in = 1'b1;
            @(posedge clk); #1;
            start_in = 1'b0;
            for (n = 1; n < 200; n++) begin
                @(posedge clk); #1;
                if (n == 9) force_busy = 1'b0;
                if (div_valid_out) break;
            end
            if (pass == 0) begin
                base = n;
                vec_cnt++; if (base !== 5) begin err_cnt++; $display("FAIL busy_hold baseline latency: got %0d want 5", base); end
            end else begin
                vec_cnt++; if (n !== base + 5) begin err_cnt++; $display("FAIL busy_hold delayed latency: got %0d want %0d", n, base + 5); end
                vec_cnt++; if (dividend_out !== 32'd100 || divisor_out !== 32'd100) begin err_cnt++; $display("FAIL busy_hold operands: got %0d/%0d want 100/100", dividend_out, divisor_out); end
                @(posedge clk); #1;
                vec_cnt++; if (div_valid_out !== 1'b0) begin err_cnt++; $display("FAIL busy_hold pulse width: got %b want 0", div_valid_out); end
            end
            for (k = 0; k < 2000; k++) begin
                if (valid_out) break;
                @(posedge clk); #1;
            end
            vec_cnt++; if (k >= 2000 || tau_out !== 3'd1 || min_val_out !== 11'd1024) begin err_cnt++; $display("FAIL busy_hold result pass %0d: got tau=%0d min=%0d want 1/1024", pass, tau_out, min_val_out); end
            repeat (5) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_in = 1'b1;
        start_in = 1'b0;
        force_busy = 1'b0;
        set_d(0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_flat();
        test_early_stop();
        test_zero();
        test_bypass();
        test_div_err();
        test_descend();
        test_last_tau();
        test_restart_ignored();
        test_reset_in_wait();
        test_busy_hold();
        vec_cnt++; if (prot_viol !== 0) begin err_cnt++; $display("FAIL divider protocol: got %0d violations want 0", prot_viol); end
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
